// File: rtl/const_div_serial.sv
// Serial divide-by-constant: K quotient bits per cycle, MSB digit first, remainder recurrence.
// Result is valid NDIG edges after accept and held until out_ready; in_ready drops while a division runs.
module const_div_serial #(
    parameter int DW  = 60,
    parameter int DIV = 241,
    parameter int K   = 8,
    parameter int RW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_dividend,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_quotient,
    output logic [RW-1:0] out_remainder,
    output logic          busy
);
    localparam int NDIG = (DW + K - 1) / K;
    localparam int PW   = NDIG * K;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int TW   = RW + K;
    localparam logic [TW-1:0] DIV_T = TW'(DIV);

    if (DIV < 2 || DIV > (2 ** RW) - 1) begin : g_bad_div
        $error("const_div_serial: DIV must satisfy 2 <= DIV <= 2**RW - 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   sreg;
    logic [PW-1:0]   quot;
    logic [PW-1:0]   quot_nxt;
    logic [RW-1:0]   rem;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic [TW-1:0]   t;
    logic [TW-1:0]   q_full;
    logic [TW-1:0]   r_full;
    logic [K-1:0]    q_dig;
    logic [RW-1:0]   r_dig;

    // Digit stage: divide by a constant, exact because t < DIV * 2**K.
    always_comb begin
        t        = {rem, sreg[PW-1 -: K]};
        q_full   = t / DIV_T;
        r_full   = t % DIV_T;
        q_dig    = q_full[K-1:0];
        r_dig    = r_full[RW-1:0];
        quot_nxt = (quot << K) | PW'(q_dig);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        accept    = in_valid && in_ready && !flush;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = RUN;
                RUN:     if (cnt == '0) state_nxt = DONE;
                DONE: begin
                    if (accept)         state_nxt = RUN;
                    else if (out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg          <= '0;
            quot          <= '0;
            rem           <= '0;
            cnt           <= '0;
            out_quotient  <= '0;
            out_remainder <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            sreg <= PW'(in_dividend);
            quot <= '0;
            rem  <= '0;
            cnt  <= CW'(NDIG - 1);
        end else if (state == RUN) begin
            sreg <= sreg << K;
            rem  <= r_dig;
            quot <= quot_nxt;
            if (cnt == '0) begin
                out_quotient  <= quot_nxt[DW-1:0];
                out_remainder <= r_dig;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);

    digit_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RUN) |-> (q_full[TW-1:K] == '0 && r_full[TW-1:RW] == '0));

    // Zero padding above DW can only produce zero quotient digits.
    if (PW > DW) begin : g_pad_chk
        pad_zero: assert property (@(posedge clk) disable iff (!rst_n)
            (state == DONE) |-> (quot[PW-1:DW] == '0));
    end
endmodule
